// File: rtl/cache_line_mover.sv
// Moves one 256-bit cache line between a cache bank and AXI: optional 8-beat
// victim write-back, then an 8-beat refill read presented as a one-cycle fill.
module cache_line_mover #(
  parameter int         LINE_WORDS = 8,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic         clk,
  input  logic         resetn,

  input  logic         req_valid,
  output logic         req_ready,
  input  logic [31:0]  req_addr,
  input  logic         req_wb,
  input  logic [31:0]  req_wb_addr,
  input  logic [255:0] req_wb_data,

  output logic         ar_valid,
  input  logic         ar_ready,
  output logic [31:0]  ar_addr,
  output logic [3:0]   ar_id,
  output logic [7:0]   ar_len,
  output logic [2:0]   ar_size,
  output logic [1:0]   ar_burst,

  input  logic         r_valid,
  output logic         r_ready,
  input  logic [31:0]  r_data,
  input  logic [1:0]   r_resp,
  input  logic         r_last,

  output logic         aw_valid,
  input  logic         aw_ready,
  output logic [31:0]  aw_addr,
  output logic [3:0]   aw_id,
  output logic [7:0]   aw_len,
  output logic [2:0]   aw_size,
  output logic [1:0]   aw_burst,

  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_data,
  output logic [3:0]   w_strb,
  output logic         w_last,

  input  logic         b_valid,
  output logic         b_ready,
  input  logic [1:0]   b_resp,

  output logic         fill_valid,
  output logic [31:0]  fill_addr,
  output logic [255:0] fill_data,
  output logic         err
);

  localparam int         LINE_BITS = 32 * LINE_WORDS;
  localparam logic [2:0] LAST_BEAT = 3'(LINE_WORDS - 1);
  localparam logic [7:0] BURST_LEN = 8'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WB_AW,
    WB_W,
    WB_B,
    RD_AR,
    RD_R,
    FILL
  } state_e;

  state_e                 state_q, state_d;
  logic [2:0]             beat_q, beat_d;
  logic                   err_q, err_d;
  logic [26:0]            line_q, line_d;
  logic [26:0]            wb_line_q, wb_line_d;
  logic [LINE_BITS-1:0]   wb_data_q, wb_data_d;
  logic [LINE_BITS-1:0]   fill_data_q, fill_data_d;
  logic [31:0]            wb_words [LINE_WORDS];

  // Offset bits inside a line carry no meaning for whole-line transfers.
  logic unused_offsets;
  assign unused_offsets = ^{req_addr[4:0], req_wb_addr[4:0]};

  // Word view of the latched victim so the write beat is a plain mux.
  generate
    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_wb_word
      assign wb_words[gi] = wb_data_q[32*gi +: 32];
    end
  endgenerate

  assign ar_addr   = {line_q, 5'd0};
  assign ar_id     = AXI_ID;
  assign ar_len    = BURST_LEN;
  assign ar_size   = 3'd2;
  assign ar_burst  = 2'd1;

  assign aw_addr   = {wb_line_q, 5'd0};
  assign aw_id     = AXI_ID;
  assign aw_len    = BURST_LEN;
  assign aw_size   = 3'd2;
  assign aw_burst  = 2'd1;

  assign w_data    = wb_words[beat_q];
  assign w_strb    = 4'hF;
  assign w_last    = (beat_q == LAST_BEAT);

  assign fill_addr = {line_q, 5'd0};
  assign fill_data = fill_data_q;
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      beat_q      <= 3'd0;
      err_q       <= 1'b0;
      line_q      <= '0;
      wb_line_q   <= '0;
      wb_data_q   <= '0;
      fill_data_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
      line_q      <= line_d;
      wb_line_q   <= wb_line_d;
      wb_data_q   <= wb_data_d;
      fill_data_q <= fill_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    err_d       = err_q;
    line_d      = line_q;
    wb_line_d   = wb_line_q;
    wb_data_d   = wb_data_q;
    fill_data_d = fill_data_q;
    req_ready   = 1'b0;
    aw_valid    = 1'b0;
    w_valid     = 1'b0;
    b_ready     = 1'b0;
    ar_valid    = 1'b0;
    r_ready     = 1'b0;
    fill_valid  = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          line_d    = req_addr[31:5];
          wb_line_d = req_wb_addr[31:5];
          wb_data_d = req_wb_data;
          err_d     = 1'b0;
          beat_d    = 3'd0;
          state_d   = req_wb ? WB_AW : RD_AR;
        end
      end

      WB_AW: begin
        aw_valid = 1'b1;
        if (aw_ready) state_d = WB_W;
      end

      WB_W: begin
        w_valid = 1'b1;
        if (w_ready) begin
          beat_d = beat_q + 3'd1;
          if (beat_q == LAST_BEAT) state_d = WB_B;
        end
      end

      WB_B: begin
        b_ready = 1'b1;
        if (b_valid) begin
          if (b_resp != 2'd0) err_d = 1'b1;
          state_d = RD_AR;
        end
      end

      RD_AR: begin
        ar_valid = 1'b1;
        if (ar_ready) state_d = RD_R;
      end

      // The burst length is fixed; r_last only feeds the error flag.
      RD_R: begin
        r_ready = 1'b1;
        if (r_valid) begin
          fill_data_d[{beat_q, 5'd0} +: 32] = r_data;
          beat_d = beat_q + 3'd1;
          if ((r_resp != 2'd0) || (r_last != (beat_q == LAST_BEAT))) err_d = 1'b1;
          if (beat_q == LAST_BEAT) state_d = FILL;
        end
      end

      FILL: begin
        fill_valid = 1'b1;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_line_mover.sv
// Directed and randomized line transfers against a transaction-level model of
// the expected bus traffic, fill contents, timing and error flag.
module tb_cache_line_mover;

  logic         clk = 1'b0;
  logic         resetn;
  logic         req_valid, req_ready, req_wb;
  logic [31:0]  req_addr, req_wb_addr;
  logic [255:0] req_wb_data;
  logic         ar_valid, ar_ready;
  logic [31:0]  ar_addr;
  logic [3:0]   ar_id;
  logic [7:0]   ar_len;
  logic [2:0]   ar_size;
  logic [1:0]   ar_burst;
  logic         r_valid, r_ready, r_last;
  logic [31:0]  r_data;
  logic [1:0]   r_resp;
  logic         aw_valid, aw_ready;
  logic [31:0]  aw_addr;
  logic [3:0]   aw_id;
  logic [7:0]   aw_len;
  logic [2:0]   aw_size;
  logic [1:0]   aw_burst;
  logic         w_valid, w_ready, w_last;
  logic [31:0]  w_data;
  logic [3:0]   w_strb;
  logic         b_valid, b_ready;
  logic [1:0]   b_resp;
  logic         fill_valid, err;
  logic [31:0]  fill_addr;
  logic [255:0] fill_data;

  int   n_vec = 0;
  int   n_bad = 0;
  logic last_err;

  typedef struct packed {
    logic [31:0]  addr;
    logic         wb;
    logic [31:0]  wb_addr;
    logic [255:0] wbd;
    logic [255:0] rdd;
    logic [15:0]  rresp;
    logic [3:0]   last_pos;
    logic [1:0]   bresp;
    logic [3:0]   aw_delay;
    logic [3:0]   ar_delay;
    logic [3:0]   b_delay;
    logic [3:0]   r_gap;
    logic [1:0]   w_mode;
    logic         r_rand;
  } txn_t;

  always #5 clk = ~clk;

  cache_line_mover #(.LINE_WORDS(8), .AXI_ID(4'd0)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wb(req_wb), .req_wb_addr(req_wb_addr), .req_wb_data(req_wb_data),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_id(aw_id),
    .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data), .err(err)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_bus();
    aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = 2'd0;
    ar_ready = 1'b0; r_valid = 1'b0; r_data = 32'd0; r_resp = 2'd0; r_last = 1'b0;
  endtask

  task automatic drive_req(input txn_t t, input logic v);
    req_valid   = v;
    req_addr    = t.addr;
    req_wb      = t.wb;
    req_wb_addr = t.wb_addr;
    req_wb_data = t.wbd;
  endtask

  function automatic txn_t base_txn(input logic [31:0] addr);
    txn_t t;
    t = '0;
    t.addr     = addr;
    t.last_pos = 4'd7;
    for (int i = 0; i < 8; i++) t.rdd[32*i +: 32] = 32'hA0 + 32'(i);
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    int   k;
    t = base_txn($urandom);
    t.wb      = 1'($urandom_range(0, 1));
    t.wb_addr = $urandom;
    for (int i = 0; i < 8; i++) begin
      t.wbd[32*i +: 32] = $urandom;
      t.rdd[32*i +: 32] = $urandom;
    end
    if ($urandom_range(0, 5) == 0) begin
      k = $urandom_range(0, 7);
      t.rresp[2*k +: 2] = 2'($urandom_range(1, 3));
    end
    if ($urandom_range(0, 7) == 0) t.last_pos = 4'($urandom_range(0, 8));
    if ($urandom_range(0, 5) == 0) t.bresp = 2'($urandom_range(1, 3));
    t.aw_delay = 4'($urandom_range(0, 3));
    t.ar_delay = 4'($urandom_range(0, 3));
    t.b_delay  = 4'($urandom_range(0, 3));
    t.r_gap    = 4'($urandom_range(0, 2));
    t.w_mode   = 2'($urandom_range(0, 2));
    t.r_rand   = 1'($urandom_range(0, 1));
    return t;
  endfunction

  // Called at a falling edge; returns at a falling edge with the DUT idle.
  task automatic run_txn(input txn_t t, input bit hold, input txn_t nx,
                         input int abort_wbeat, input int best_fill);
    int          wi, rk, aw_cnt, ar_cnt, b_cnt, r_idle, fills;
    bit          aw_done, w_done, b_done, ar_done, exp_err, r_go;
    logic [31:0] line_addr, wb_line;
    txn_t        junk;
    wi = 0; rk = 0; aw_cnt = 0; ar_cnt = 0; b_cnt = 0; fills = 0;
    aw_done = 0; w_done = 0; b_done = 0; ar_done = 0; exp_err = 0;
    r_idle    = int'(t.r_gap);
    line_addr = {t.addr[31:5], 5'd0};
    wb_line   = {t.wb_addr[31:5], 5'd0};

    check("err_held_to_accept", 256'(err), 256'(last_err));
    drive_req(t, 1'b1);
    check("req_ready_idle", 256'(req_ready), 256'(1));
    @(posedge clk);

    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (hold) drive_req(nx, 1'b1);
        else begin
          junk = rand_txn();
          drive_req(junk, 1'b0);
        end
      end

      if (fills > 0) begin
        clear_bus();
        check("req_ready_after_fill", 256'(req_ready), 256'(1));
        check("fill_valid_one_cycle", 256'(fill_valid), 256'(0));
        check("fill_data_hold", fill_data, t.rdd);
        check("err_after_fill", 256'(err), 256'(exp_err));
        last_err = exp_err;
        return;
      end

      check("err", 256'(err), 256'(exp_err));
      check("req_ready_busy", 256'(req_ready), 256'(0));

      if (abort_wbeat >= 0 && w_valid && wi == abort_wbeat) begin
        clear_bus();
        req_valid = 1'b0;
        resetn    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 256'(req_ready), 256'(1));
        check("rst_aw_valid", 256'(aw_valid), 256'(0));
        check("rst_w_valid", 256'(w_valid), 256'(0));
        check("rst_ar_valid", 256'(ar_valid), 256'(0));
        check("rst_err", 256'(err), 256'(0));
        check("rst_fill_valid", 256'(fill_valid), 256'(0));
        check("rst_fill_data", fill_data, 256'(0));
        resetn   = 1'b1;
        last_err = 1'b0;
        return;
      end

      if (!aw_done) check("w_before_aw", 256'(w_valid), 256'(0));
      if (!t.wb) check("aw_on_clean", 256'(aw_valid), 256'(0));
      if (!w_done) check("b_ready_early", 256'(b_ready), 256'(0));
      if (t.wb && !b_done) check("ar_before_b", 256'(ar_valid), 256'(0));
      if (ar_done) check("ar_valid_after_hs", 256'(ar_valid), 256'(0));

      clear_bus();

      if (aw_valid) begin
        check("aw_addr", 256'(aw_addr), 256'(wb_line));
        check("aw_len", 256'(aw_len), 256'(7));
        aw_ready = (aw_cnt >= int'(t.aw_delay));
        aw_cnt++;
        if (aw_ready) aw_done = 1;
      end

      if (w_done && !b_done) begin
        b_cnt++;
        b_valid = (b_cnt > int'(t.b_delay));
        b_resp  = t.bresp;
        if (b_valid && b_ready) begin
          b_done  = 1;
          exp_err = exp_err | (t.bresp != 2'd0);
        end
      end

      if (w_valid) begin
        case (t.w_mode)
          2'd0:    w_ready = 1'b1;
          2'd1:    w_ready = 1'(c % 2);
          default: w_ready = 1'($urandom_range(0, 1));
        endcase
        if (w_ready) begin
          if (wi < 8) begin
            check("w_data", 256'(w_data), 256'(t.wbd[32*wi +: 32]));
            check("w_last", 256'(w_last), 256'(wi == 7));
            check("w_strb", 256'(w_strb), 256'(4'hF));
          end else begin
            check("w_extra_beat", 256'(w_valid), 256'(0));
          end
          wi++;
          if (wi == 8) w_done = 1;
        end
      end

      if (ar_done && rk < 8) begin
        if (t.r_rand) r_go = 1'($urandom_range(0, 1));
        else          r_go = (r_idle >= int'(t.r_gap));
        if (r_go) begin
          r_valid = 1'b1;
          r_data  = t.rdd[32*rk +: 32];
          r_resp  = t.rresp[2*rk +: 2];
          r_last  = (rk == int'(t.last_pos));
        end else begin
          r_idle++;
        end
        if (r_valid && r_ready) begin
          exp_err = exp_err | (r_resp != 2'd0) | (r_last != (rk == 7));
          rk++;
          r_idle = 0;
        end
      end else if (rk == 8) begin
        check("r_ready_after_8", 256'(r_ready), 256'(0));
        r_valid = 1'b1;
        r_data  = $urandom;
        r_last  = 1'b1;
      end

      if (ar_valid) begin
        check("ar_addr", 256'(ar_addr), 256'(line_addr));
        check("ar_len", 256'(ar_len), 256'(7));
        check("ar_size", 256'(ar_size), 256'(2));
        check("ar_burst", 256'(ar_burst), 256'(1));
        check("ar_id", 256'(ar_id), 256'(0));
        ar_ready = (ar_cnt >= int'(t.ar_delay));
        ar_cnt++;
        if (ar_ready) ar_done = 1;
      end

      if (fill_valid) begin
        fills++;
        check("fill_addr", 256'(fill_addr), 256'(line_addr));
        check("fill_data", fill_data, t.rdd);
        check("fill_after_8_beats", 256'(rk), 256'(8));
        if (best_fill > 0) check("fill_cycle", 256'(c), 256'(best_fill));
      end
    end

    check("timeout_fill", 256'(fills), 256'(1));
    clear_bus();
    req_valid = 1'b0;
    resetn    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetn   = 1'b1;
    last_err = 1'b0;
  endtask

  initial begin
    txn_t t0, t1, cur, nxt, none;
    bit   hold;

    resetn = 1'b0;
    clear_bus();
    none = base_txn(32'd0);
    drive_req(none, 1'b0);
    last_err = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    check("reset_req_ready", 256'(req_ready), 256'(1));
    check("reset_valids", 256'({aw_valid, w_valid, ar_valid, b_ready, r_ready}), 256'(0));
    check("reset_fill_valid", 256'(fill_valid), 256'(0));
    check("reset_err", 256'(err), 256'(0));
    check("reset_fill_data", fill_data, 256'(0));
    check("reset_ar_len", 256'(ar_len), 256'(7));
    check("reset_aw_consts", 256'({aw_id, aw_len, aw_size, aw_burst}), 256'({4'd0, 8'd7, 3'd2, 2'd1}));
    check("reset_w_strb", 256'(w_strb), 256'(4'hF));
    resetn = 1'b1;

    // Clean miss, no stalls.
    t0 = base_txn(32'h1000_0034);
    run_txn(t0, 0, none, -1, 10);

    // Dirty miss with every slave ready.
    t0 = base_txn(32'h1234_5678);
    t0.wb = 1'b1;
    t0.wb_addr = 32'h3000_009F;
    for (int i = 0; i < 8; i++) t0.wbd[32*i +: 32] = $urandom;
    run_txn(t0, 0, none, -1, 20);

    // Dirty miss: slow AW, toggling W ready.
    t0 = base_txn(32'h1000_0100);
    t0.wb = 1'b1;
    t0.wb_addr = 32'h2000_0040;
    for (int i = 0; i < 8; i++) t0.wbd[32*i +: 32] = 32'h100 + 32'(i);
    t0.aw_delay = 4'd3;
    t0.w_mode   = 2'd1;
    run_txn(t0, 0, none, -1, 0);

    // Two idle cycles between every read beat.
    t0 = base_txn(32'h1000_0034);
    t0.r_gap = 4'd2;
    run_txn(t0, 0, none, -1, 0);

    // SLVERR on read beat 3: fill still happens, err sticks.
    t0 = base_txn(32'h1000_0200);
    t0.rresp[7:6] = 2'd2;
    run_txn(t0, 0, none, -1, 10);

    // Next accept must clear err.
    t0 = base_txn(32'h4000_0000);
    run_txn(t0, 0, none, -1, 10);

    // Early r_last on beat 5.
    t0 = base_txn(32'h1000_0300);
    t0.last_pos = 4'd5;
    run_txn(t0, 0, none, -1, 10);

    // Reset in the middle of the victim write, then a normal miss.
    t0 = base_txn(32'h1000_0400);
    t0.wb = 1'b1;
    t0.wb_addr = 32'h2000_0080;
    for (int i = 0; i < 8; i++) t0.wbd[32*i +: 32] = $urandom;
    run_txn(t0, 0, none, 4, 0);
    t0 = base_txn(32'h1000_0034);
    run_txn(t0, 0, none, -1, 10);

    // Back-to-back with req_valid held high.
    t0 = base_txn(32'h5000_0020);
    t1 = base_txn(32'h6000_0040);
    t1.wb = 1'b1;
    t1.wb_addr = 32'h7000_0000;
    for (int i = 0; i < 8; i++) begin
      t1.wbd[32*i +: 32] = $urandom;
      t1.rdd[32*i +: 32] = $urandom;
    end
    run_txn(t0, 1, t1, -1, 10);
    run_txn(t1, 0, none, -1, 20);

    // Randomized traffic, sometimes chained back-to-back.
    cur = rand_txn();
    for (int i = 0; i < 30; i++) begin
      nxt  = rand_txn();
      hold = 1'($urandom_range(0, 1));
      run_txn(cur, hold, nxt, -1, 0);
      cur = nxt;
    end
    run_txn(cur, 0, none, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
